// File: rtl/lc3_exec_pkg.sv
// Shared definitions for the LC-3 execute stage: opcodes, control-field enums and E_control bit positions.
// No logic; pure types and constants.
// Imported by lc3_exec_alu and lc3_execute_stage.
package lc3_exec_pkg;

    // Instruction opcodes (IR[15:12])
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // ALU function select
    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_ZERO = 2'b11
    } alu_ctl_e;

    // Address-adder first-term select
    typedef enum logic [1:0] {
        PC1_OFF11 = 2'b00,
        PC1_OFF9  = 2'b01,
        PC1_OFF6  = 2'b10,
        PC1_ZERO  = 2'b11
    } pcsel1_e;

    // E_control field positions
    localparam int EC_ALU_HI  = 5;
    localparam int EC_ALU_LO  = 4;
    localparam int EC_PC1_HI  = 3;
    localparam int EC_PC1_LO  = 2;
    localparam int EC_PC2     = 1;
    localparam int EC_OP2SEL  = 0;

endpackage

// File: rtl/lc3_exec_alu.sv
// Combinational ALU, PC-relative address adder and IR offset sign-extenders.
// Latency: zero (pure combinational).
// No flow control; results are registered by the enclosing stage.
module lc3_exec_alu
    import lc3_exec_pkg::*;
(
    input  logic [15:0] op1_i,
    input  logic [15:0] op2v_i,
    input  logic [15:0] npc_i,
    input  logic [10:0] imm_i,
    input  logic [5:0]  e_control_i,
    output logic [15:0] alu_o,
    output logic [15:0] pc_o
);

    logic [15:0] sext5, sext6, sext9, sext11;
    logic [15:0] alu_b, pc_a, pc_b;
    alu_ctl_e    alu_ctl;
    pcsel1_e     pc_sel1;

    assign sext5  = {{11{imm_i[4]}},  imm_i[4:0]};
    assign sext6  = {{10{imm_i[5]}},  imm_i[5:0]};
    assign sext9  = {{7{imm_i[8]}},   imm_i[8:0]};
    assign sext11 = {{5{imm_i[10]}},  imm_i[10:0]};

    assign alu_ctl = alu_ctl_e'(e_control_i[EC_ALU_HI:EC_ALU_LO]);
    assign pc_sel1 = pcsel1_e'(e_control_i[EC_PC1_HI:EC_PC1_LO]);

    assign alu_b = e_control_i[EC_OP2SEL] ? op2v_i : sext5;
    assign pc_b  = e_control_i[EC_PC2]    ? npc_i  : op1_i;

    // ALU function; add wraps modulo 2^16 with carry discarded
    always_comb begin
        alu_o = 16'h0000;
        case (alu_ctl)
            ALU_ADD:  alu_o = op1_i + alu_b;
            ALU_AND:  alu_o = op1_i & alu_b;
            ALU_NOT:  alu_o = ~op1_i;
            default:  alu_o = 16'h0000;
        endcase
    end

    // Address adder first term: IR offset of the width the instruction format uses
    always_comb begin
        pc_a = 16'h0000;
        case (pc_sel1)
            PC1_OFF11: pc_a = sext11;
            PC1_OFF9:  pc_a = sext9;
            PC1_OFF6:  pc_a = sext6;
            default:   pc_a = 16'h0000;
        endcase
    end

    assign pc_o = pc_a + pc_b;

endmodule

// File: rtl/lc3_execute_stage.sv
// LC-3 execute stage: operand forwarding, ALU/address compute, register decode, pipeline registers.
// Latency: one cycle for registered outputs; sr1/sr2 are combinational from IR.
// enable_execute=0 holds every register; forwarding muxes exist only with EXEC_BYPASS_EN defined.
module lc3_execute_stage
    import lc3_exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_execute,
    input  logic [5:0]        E_control,
    input  logic [DATA_W-1:0] IR,
    input  logic [DATA_W-1:0] npc_in,
    input  logic [1:0]        W_control_in,
    input  logic              Mem_Control_in,
    input  logic [DATA_W-1:0] VSR1,
    input  logic [DATA_W-1:0] VSR2,
    input  logic              bypass_alu_1,
    input  logic              bypass_alu_2,
    input  logic              bypass_mem_1,
    input  logic              bypass_mem_2,
    input  logic [DATA_W-1:0] Mem_Bypass_Val,
    output logic [1:0]        W_control_out,
    output logic              Mem_Control_out,
    output logic [DATA_W-1:0] alutout,
    output logic [DATA_W-1:0] pcout,
    output logic [REG_W-1:0]  dr,
    output logic [REG_W-1:0]  sr1,
    output logic [REG_W-1:0]  sr2,
    output logic [DATA_W-1:0] IR_Exec,
    output logic [2:0]        NZP,
    output logic [DATA_W-1:0] M_data
);

    logic [15:0] op1, op2v;
    logic [15:0] alutout_d, pcout_d;
    logic [15:0] alutout_q, pcout_q, ir_q, m_data_q;
    logic [2:0]  dr_d, dr_q, nzp_d, nzp_q;
    logic [1:0]  w_control_q;
    logic        mem_control_q;
    logic [3:0]  opcode;

    assign opcode = IR[15:12];

`ifdef EXEC_BYPASS_EN
    // Operand forwarding; ALU self-forward beats memory forward
    always_comb begin
        op1 = VSR1;
        if (bypass_alu_1)      op1 = alutout_q;
        else if (bypass_mem_1) op1 = Mem_Bypass_Val;
        op2v = VSR2;
        if (bypass_alu_2)      op2v = alutout_q;
        else if (bypass_mem_2) op2v = Mem_Bypass_Val;
    end
`else
    // No forwarding: the controller stalls on hazards instead
    assign op1  = VSR1;
    assign op2v = VSR2;
    logic unused_bypass;
    assign unused_bypass = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, Mem_Bypass_Val};
`endif

    lc3_exec_alu u_alu (
        .op1_i       (op1),
        .op2v_i      (op2v),
        .npc_i       (npc_in),
        .imm_i       (IR[10:0]),
        .e_control_i (E_control),
        .alu_o       (alutout_d),
        .pc_o        (pcout_d)
    );

    // Register-index and branch-mask decode from the opcode
    always_comb begin
        dr_d  = 3'd0;
        sr2   = 3'd0;
        nzp_d = 3'b000;
        case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA: dr_d = IR[11:9];
            default: dr_d = 3'd0;
        endcase
        case (opcode)
            OP_ST, OP_STR, OP_STI: sr2 = IR[11:9];
            OP_ADD, OP_AND:        sr2 = IR[2:0];
            default:               sr2 = 3'd0;
        endcase
        case (opcode)
            OP_BR:   nzp_d = IR[11:9];
            OP_JMP:  nzp_d = 3'b111;
            default: nzp_d = 3'b000;
        endcase
    end

    assign sr1 = IR[8:6];

    // Pipeline registers toward MemAccess/Writeback; reset beats enable
    always_ff @(posedge clock) begin
        if (reset) begin
            alutout_q     <= 16'h0000;
            pcout_q       <= 16'h0000;
            ir_q          <= 16'h0000;
            m_data_q      <= 16'h0000;
            dr_q          <= 3'd0;
            nzp_q         <= 3'd0;
            w_control_q   <= 2'd0;
            mem_control_q <= 1'b0;
        end else if (enable_execute) begin
            alutout_q     <= alutout_d;
            pcout_q       <= pcout_d;
            ir_q          <= IR;
            m_data_q      <= op2v;
            dr_q          <= dr_d;
            nzp_q         <= nzp_d;
            w_control_q   <= W_control_in;
            mem_control_q <= Mem_Control_in;
        end
    end

    assign alutout         = alutout_q;
    assign pcout           = pcout_q;
    assign IR_Exec         = ir_q;
    assign M_data          = m_data_q;
    assign dr              = dr_q;
    assign NZP             = nzp_q;
    assign W_control_out   = w_control_q;
    assign Mem_Control_out = mem_control_q;

endmodule
